down_counter_reload: RTL and testbench

Loadable binary down-counter with borrow output and optional auto-reload. It is the counting-down counterpart of the team's loadable up-counter with carry. It serves as a programmable interval timer or event divider: load N, count N enabled cycles, then emit one borrow pulse. Borrow is cascadable into further counters or the up-counter's Count input.

---
 rtl/down_counter_reload_pkg.sv | 13 +
 rtl/down_counter_reload_if.sv | 27 ++
 rtl/down_counter_reload.sv | 80 ++++++++
 tb/tb_down_counter_reload.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/down_counter_reload_pkg.sv
// Shared definitions for the down-counter with borrow and auto-reload.
// The state encoding and default width are also used by the up-counter bench utilities.
package down_counter_reload_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter_reload_if.sv
// Bus bundle for the down-counter: load/count controls in, count value and status out.
interface down_counter_reload_if
    import down_counter_reload_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic [WIDTH-1:0] Data_in;
    logic             Load;
    logic             Count;
    logic             Auto_reload;
    logic [WIDTH-1:0] A_count;
    logic             B_out;
    logic             Busy;
    logic             Done;

    modport master (
        output Data_in, Load, Count, Auto_reload,
        input  A_count, B_out, Busy, Done
    );

    modport slave (
        input  Data_in, Load, Count, Auto_reload,
        output A_count, B_out, Busy, Done
    );

endinterface

// File: rtl/down_counter_reload.sv
// Loadable down-counter with a one-cycle borrow pulse at terminal count and optional auto-reload.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nothing loaded (or zero loaded); Count ignored, count holds
// RUN   | counting enabled cycles down toward the terminal count of 1
// DONE  | one-shot expired; count holds 0, Count ignored until Load
module down_counter_reload
    import down_counter_reload_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 Clear,
    down_counter_reload_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             borrow_q;
    logic             terminal;

    // The terminal count is the decrement from 1; reaching 0 any other way is impossible in RUN.
    assign terminal = (state_q == RUN) && bus.Count && (count_q == WIDTH'(1));

    // State register; Clear dominates every other event.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Load from any state wins over a coincident terminal count.
    always_comb begin
        state_d = state_q;
        if (bus.Load) begin
            state_d = (bus.Data_in != '0) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN:     if (terminal && !bus.Auto_reload) state_d = DONE;
                IDLE:    state_d = IDLE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Count/reload registers and the borrow pulse, which defaults low every edge.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            count_q  <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            borrow_q <= 1'b0;
            if (bus.Load) begin
                count_q  <= bus.Data_in;
                reload_q <= bus.Data_in;
            end else if (terminal) begin
                borrow_q <= 1'b1;
                count_q  <= bus.Auto_reload ? reload_q : '0;
            end else if ((state_q == RUN) && bus.Count && (count_q > WIDTH'(1))) begin
                count_q <= count_q - WIDTH'(1);
            end
        end
    end

    // Status outputs decode registered state only, so no input reaches them combinationally.
    always_comb begin
        bus.A_count = count_q;
        bus.B_out   = borrow_q;
        bus.Busy    = (state_q == RUN);
        bus.Done    = (state_q == DONE);
    end

endmodule

// File: tb/tb_down_counter_reload.sv
// Self-checking bench for down_counter_reload: a table of per-edge vectors plus
// hand-written sequences for the full-scale one-shot and a mid-run clear.
module tb_down_counter_reload;

    logic CLK;
    logic Clear;
    int   tests_run;
    int   tests_failed;

    down_counter_reload_if #(.WIDTH(4)) bus ();

    down_counter_reload #(.WIDTH(4)) dut (
        .CLK   (CLK),
        .Clear (Clear),
        .bus   (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       clr;
        logic       load;
        logic       cnt;
        logic       arl;
        logic [3:0] data;
        logic [3:0] exp_a;
        logic       exp_b;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic load, input logic cnt, input logic arl,
                       input logic [3:0] data, input logic [3:0] a, input logic b,
                       input logic busy, input logic done);
        vec_t v;
        v.clr = clr; v.load = load; v.cnt = cnt; v.arl = arl; v.data = data;
        v.exp_a = a; v.exp_b = b; v.exp_busy = busy; v.exp_done = done;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic clr, input logic load, input logic cnt, input logic arl,
                         input logic [3:0] data);
        Clear           = clr;
        bus.Load        = load;
        bus.Count       = cnt;
        bus.Auto_reload = arl;
        bus.Data_in     = data;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int enabled;
        int borrows;
        int k;
        tests_run    = 0;
        tests_failed = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        //   clr load cnt arl data   A  B busy done
        // Reset with Load asserted: Clear dominates.
        add(1, 1, 0, 0, 4'd6,  4'd0,  0, 0, 0);
        add(1, 1, 0, 0, 4'd6,  4'd0,  0, 0, 0);
        // One-shot from 3.
        add(0, 1, 0, 0, 4'd3,  4'd3,  0, 1, 0);
        add(0, 0, 1, 0, 4'd0,  4'd2,  0, 1, 0);
        add(0, 0, 1, 0, 4'd0,  4'd1,  0, 1, 0);
        add(0, 0, 1, 0, 4'd0,  4'd0,  1, 0, 1);
        add(0, 0, 1, 0, 4'd0,  4'd0,  0, 0, 1);
        add(0, 0, 1, 0, 4'd0,  4'd0,  0, 0, 1);
        // Auto-reload from 5 with gated enable.
        add(0, 1, 0, 1, 4'd5,  4'd5,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd4,  0, 1, 0);
        add(0, 0, 0, 1, 4'd0,  4'd4,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd3,  0, 1, 0);
        add(0, 0, 0, 1, 4'd0,  4'd3,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd2,  0, 1, 0);
        add(0, 0, 0, 1, 4'd0,  4'd2,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd1,  0, 1, 0);
        add(0, 0, 0, 1, 4'd0,  4'd1,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd5,  1, 1, 0);
        add(0, 0, 0, 1, 4'd0,  4'd5,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd4,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd3,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd2,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd1,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd5,  1, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd4,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd3,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd2,  0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd1,  0, 1, 0);
        // Load on the terminal-count edge: Load wins, no borrow.
        add(0, 1, 1, 1, 4'd10, 4'd10, 0, 1, 0);
        add(0, 0, 1, 1, 4'd0,  4'd9,  0, 1, 0);
        // Load of zero: IDLE, Count ignored.
        add(0, 1, 0, 0, 4'd0,  4'd0,  0, 0, 0);
        add(0, 0, 1, 0, 4'd0,  4'd0,  0, 0, 0);
        add(0, 0, 1, 1, 4'd0,  4'd0,  0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].cnt, vecs[i].arl, vecs[i].data);
            tick();
            chk($sformatf("vec%0d A_count", i), 32'(bus.A_count), 32'(vecs[i].exp_a));
            chk($sformatf("vec%0d B_out", i),   32'(bus.B_out),   32'(vecs[i].exp_b));
            chk($sformatf("vec%0d Busy", i),    32'(bus.Busy),    32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d Done", i),    32'(bus.Done),    32'(vecs[i].exp_done));
        end

        // Full-scale one-shot: 15 enabled edges, with gaps, to a single borrow.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
        tick();
        chk("max load A_count", 32'(bus.A_count), 32'd15);
        enabled = 0;
        borrows = 0;
        k = 0;
        while (enabled < 15 && k < 40) begin
            drive(1'b0, 1'b0, (k % 4) != 3, 1'b0, 4'd0);
            if ((k % 4) != 3) enabled++;
            tick();
            if (bus.B_out) borrows++;
            chk($sformatf("max step%0d A_count", k), 32'(bus.A_count), 32'(15 - enabled));
            chk($sformatf("max step%0d B_out", k), 32'(bus.B_out), (enabled == 15) ? 32'd1 : 32'd0);
            k++;
        end
        chk("max enabled edges", 32'(enabled), 32'd15);
        chk("max Done", 32'(bus.Done), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        tick();
        if (bus.B_out) borrows++;
        chk("max borrow count", 32'(borrows), 32'd1);

        // Mid-run clear at A_count=7 aborts with no borrow, ever.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        tick();
        chk("midrun A_count before clear", 32'(bus.A_count), 32'd7);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        tick();
        chk("midrun clear A_count", 32'(bus.A_count), 32'd0);
        chk("midrun clear Busy", 32'(bus.Busy), 32'd0);
        chk("midrun clear Done", 32'(bus.Done), 32'd0);
        borrows = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        for (int j = 0; j < 12; j++) begin
            tick();
            if (bus.B_out) borrows++;
        end
        chk("midrun no borrow", 32'(borrows), 32'd0);
        chk("midrun idle A_count", 32'(bus.A_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
